// File: rtl/axi_write_slave.sv
// axi_write_slave: single-outstanding AXI4 write slave backed by an on-chip
// word memory, with a combinational backdoor read port for inspection.
// Supports FIXED, INCR and WRAP bursts. Protocol irregularities (WLAST/beat
// count mismatch, out-of-range beats, reserved burst type, illegal WRAP
// length) are absorbed and reported as SLVERR on the B channel.
// Optional build macro AXI_WRITE_SLAVE_WAIT_EN: when defined, WREADY during
// the data phase is throttled by bit 0 of a free-running 8-bit LFSR
// (x^8+x^6+x^5+x^4+1, seed 8'hA5) to exercise master back-pressure.

module axi_write_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,

  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,

  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,

  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,

  input  logic [ADDR_WIDTH-1:0]   DBG_ADDR,
  output logic [DATA_WIDTH-1:0]   DBG_RDATA
);

  localparam int STRB  = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(STRB);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP_A    = ADDR_WIDTH'(STRB);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(STRB - 1);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_cnt;
  logic [1:0]              burst_q;
  logic                    err_q;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                    aw_hs;
  logic                    w_hs;
  logic                    wrap_len_ok;
  logic                    aw_bad;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    in_range;
  logic                    at_final;
  logic                    last_beat;
  logic                    beat_err;
  logic [ADDR_WIDTH-1:0]   incr_addr;
  logic [ADDR_WIDTH-1:0]   wrap_mask;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic                    wr_gate;
  logic [ADDR_WIDTH-1:0]   dbg_idx;

`ifdef AXI_WRITE_SLAVE_WAIT_EN
  logic [7:0]              lfsr;
  logic [7:0]              lfsr_next;

  // Next LFSR value; WREADY registers bit 0 of it so the registered
  // output always mirrors bit 0 of the LFSR state in the same cycle.
  always_comb begin
    lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    wr_gate   = lfsr_next[0];
  end

  // Free-running pseudo-random throttle source, reseeded on reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= lfsr_next;
    end
  end
`else
  // No throttling: the data channel is always ready while in DATA.
  always_comb begin
    wr_gate = 1'b1;
  end
`endif

  // Handshake qualifiers and per-beat bookkeeping derived from the burst
  // context; the registered READY flags already encode the current state.
  always_comb begin
    aw_hs       = AWVALID & AWREADY;
    w_hs        = WVALID & WREADY;
    wrap_len_ok = (AWLEN == 8'd1) || (AWLEN == 8'd3) ||
                  (AWLEN == 8'd7) || (AWLEN == 8'd15);
    aw_bad      = (AWBURST == BURST_RSVD) ||
                  ((AWBURST == BURST_WRAP) && !wrap_len_ok);
    word_idx    = addr_q >> SHIFT;
    in_range    = (word_idx < DEPTH_A);
    at_final    = (beat_cnt == len_q);
    last_beat   = WLAST | at_final;
    beat_err    = (WLAST != at_final) | ~in_range;
  end

  // Address sequencing. The wrap window is (len+1)*STRB bytes; since len+1
  // is a power of two for legal WRAP bursts, the window mask is simply
  // len*STRB + STRB-1.
  always_comb begin
    incr_addr = addr_q + STEP_A;
    wrap_mask = (ADDR_WIDTH'(len_q) << SHIFT) | LANE_MASK;
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

  // Burst control FSM: address phase, data phase, response phase, with all
  // channel handshake outputs registered.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= IDLE;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      BID      <= '0;
      BRESP    <= RESP_OKAY;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      burst_q  <= BURST_INCR;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q     <= AWID;
            addr_q   <= AWADDR;
            len_q    <= AWLEN;
            beat_cnt <= '0;
            burst_q  <= aw_bad ? BURST_INCR : AWBURST;
            err_q    <= aw_bad;
            AWREADY  <= 1'b0;
            WREADY   <= wr_gate;
            state    <= DATA;
          end else begin
            AWREADY  <= 1'b1;
          end
        end

        DATA: begin
          if (w_hs) begin
            addr_q   <= next_addr;
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) begin
              WREADY <= 1'b0;
              BVALID <= 1'b1;
              BID    <= id_q;
              BRESP  <= (err_q | beat_err) ? RESP_SLVERR : RESP_OKAY;
              state  <= RESP;
            end else begin
              err_q  <= err_q | beat_err;
              WREADY <= wr_gate;
            end
          end else begin
            WREADY <= wr_gate;
          end
        end

        RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            state   <= IDLE;
          end
        end

        default: begin
          AWREADY <= 1'b0;
          WREADY  <= 1'b0;
          BVALID  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Byte-enabled memory write on each accepted beat; beats outside the
  // memory are dropped. Memory contents survive reset.
  always_ff @(posedge ACLK) begin
    if (w_hs && in_range) begin
      for (int b = 0; b < STRB; b++) begin
        if (WSTRB[b]) begin
          mem[word_idx[IDX_W-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
        end
      end
    end
  end

  // Backdoor read for inspection; out-of-range addresses read as zero.
  always_comb begin
    dbg_idx = DBG_ADDR >> SHIFT;
    if (dbg_idx < DEPTH_A) begin
      DBG_RDATA = mem[dbg_idx[IDX_W-1:0]];
    end else begin
      DBG_RDATA = '0;
    end
  end

endmodule

// File: tb/tb_axi_write_slave.sv
// tb_axi_write_slave: directed testbench for axi_write_slave covering reset,
// INCR/WRAP/FIXED bursts, error responses, B back-pressure and mid-burst reset.

module tb_axi_write_slave;

  logic        ACLK;
  logic        ARESETn;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] DBG_ADDR;
  logic [31:0] DBG_RDATA;

  int total;
  int bad;

  axi_write_slave #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .DBG_ADDR(DBG_ADDR), .DBG_RDATA(DBG_RDATA)
  );

  // 100 MHz clock
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Drive one AW transfer; returns one cycle after the handshake edge.
  task automatic apply_aw(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst);
    logic hs;
    int   n;
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    do begin
      hs = AWREADY;
      @(posedge ACLK); #1;
      n++;
    end while (!hs && n < 50);
    AWVALID = 1'b0;
    total++;
    if (!hs) begin
      bad++;
      $display("[TB] FAIL aw_timeout awready=%0b required=1 within 50 cycles", AWREADY);
    end
  endtask

  // Drive one W beat; returns one cycle after the handshake edge.
  task automatic apply_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    logic hs;
    int   n;
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    n = 0;
    do begin
      hs = WREADY;
      @(posedge ACLK); #1;
      n++;
    end while (!hs && n < 50);
    WVALID = 1'b0; WLAST = 1'b0;
    total++;
    if (!hs) begin
      bad++;
      $display("[TB] FAIL w_timeout wready=%0b required=1 within 50 cycles", WREADY);
    end
  endtask

  // Accept one B response, capturing ID and response at the handshake.
  task automatic apply_b(output logic got, output logic [3:0] id, output logic [1:0] resp);
    int n;
    BREADY = 1'b1;
    n = 0;
    got = 1'b0; id = 'x; resp = 'x;
    do begin
      got = BVALID; id = BID; resp = BRESP;
      @(posedge ACLK); #1;
      n++;
    end while (!got && n < 50);
    BREADY = 1'b0;
  endtask

  task automatic test_reset;
    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    total++;
    if ({AWREADY, WREADY, BVALID} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_ready got=%b required=000", {AWREADY, WREADY, BVALID});
    end
    total++;
    if ({BID, BRESP} !== 6'b0) begin
      bad++; $display("[TB] FAIL reset_bid_bresp got=%h/%b required=0/00", BID, BRESP);
    end
    ARESETn = 1'b1;
    #1;
    total++;
    if (AWREADY !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_awready_early got=%b required=0", AWREADY);
    end
    @(posedge ACLK); #1;
    total++;
    if (AWREADY !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_awready_rise got=%b required=1", AWREADY);
    end
  endtask

  task automatic test_incr;
    logic got; logic [3:0] id; logic [1:0] resp;
    apply_aw(4'h5, 32'h10, 8'd3, 2'b01);
    total++;
    if (WREADY !== 1'b1) begin
      bad++; $display("[TB] FAIL incr_wready got=%b required=1", WREADY);
    end
    for (int i = 0; i < 4; i++) apply_w(32'(i + 1), 4'hF, i == 3);
    total++;
    if (BVALID !== 1'b1) begin
      bad++; $display("[TB] FAIL incr_bvalid got=%b required=1", BVALID);
    end
    apply_b(got, id, resp);
    total++;
    if ({got, id, resp} !== {1'b1, 4'h5, 2'b00}) begin
      bad++; $display("[TB] FAIL incr_bresp got=%b/%h/%b required=1/5/00", got, id, resp);
    end
    total++;
    if (AWREADY !== 1'b1) begin
      bad++; $display("[TB] FAIL incr_awready_after_b got=%b required=1", AWREADY);
    end
    for (int i = 0; i < 4; i++) begin
      DBG_ADDR = 32'h10 + 32'(4 * i); #1;
      total++;
      if (DBG_RDATA !== 32'(i + 1)) begin
        bad++; $display("[TB] FAIL incr_mem[%0d] got=%h required=%h", i, DBG_RDATA, i + 1);
      end
    end
  endtask

  task automatic test_wrap;
    logic got; logic [3:0] id; logic [1:0] resp;
    logic [31:0] exp_addr [4];
    exp_addr = '{32'h38, 32'h3C, 32'h30, 32'h34};
    apply_aw(4'h3, 32'h38, 8'd3, 2'b10);
    for (int i = 0; i < 4; i++) apply_w(32'hA0 + 32'(i), 4'hF, i == 3);
    apply_b(got, id, resp);
    total++;
    if ({got, id, resp} !== {1'b1, 4'h3, 2'b00}) begin
      bad++; $display("[TB] FAIL wrap_bresp got=%b/%h/%b required=1/3/00", got, id, resp);
    end
    for (int i = 0; i < 4; i++) begin
      DBG_ADDR = exp_addr[i]; #1;
      total++;
      if (DBG_RDATA !== 32'hA0 + 32'(i)) begin
        bad++; $display("[TB] FAIL wrap_mem@%h got=%h required=%h", exp_addr[i], DBG_RDATA, 32'hA0 + i);
      end
    end
  endtask

  task automatic test_fixed;
    logic got; logic [3:0] id; logic [1:0] resp;
    apply_aw(4'h1, 32'h0, 8'd1, 2'b00);
    apply_w(32'h0000_00AA, 4'b0001, 1'b0);
    apply_w(32'h0000_BB00, 4'b0010, 1'b1);
    apply_b(got, id, resp);
    total++;
    if ({got, resp} !== 3'b100) begin
      bad++; $display("[TB] FAIL fixed_bresp got=%b/%b required=1/00", got, resp);
    end
    DBG_ADDR = 32'h0; #1;
    total++;
    if (DBG_RDATA[15:0] !== 16'hBBAA) begin
      bad++; $display("[TB] FAIL fixed_word0 got=%h required=BBAA", DBG_RDATA[15:0]);
    end
  endtask

  task automatic test_early_wlast;
    logic got; logic [3:0] id; logic [1:0] resp;
    apply_aw(4'h7, 32'h80, 8'd3, 2'b01);
    apply_w(32'h11, 4'hF, 1'b0);
    apply_w(32'h22, 4'hF, 1'b1);
    total++;
    if ({BVALID, WREADY} !== 2'b10) begin
      bad++; $display("[TB] FAIL early_wlast_end got=%b required=10", {BVALID, WREADY});
    end
    apply_b(got, id, resp);
    total++;
    if ({got, id, resp} !== {1'b1, 4'h7, 2'b10}) begin
      bad++; $display("[TB] FAIL early_wlast_bresp got=%b/%h/%b required=1/7/10", got, id, resp);
    end
    DBG_ADDR = 32'h84; #1;
    total++;
    if (DBG_RDATA !== 32'h22) begin
      bad++; $display("[TB] FAIL early_wlast_mem got=%h required=22", DBG_RDATA);
    end
  endtask

  task automatic test_beat_limit;
    logic got; logic [3:0] id; logic [1:0] resp;
    apply_aw(4'h6, 32'hE0, 8'd1, 2'b01);
    apply_w(32'h1, 4'hF, 1'b0);
    apply_w(32'h2, 4'hF, 1'b0);
    total++;
    if (BVALID !== 1'b1) begin
      bad++; $display("[TB] FAIL beat_limit_bvalid got=%b required=1", BVALID);
    end
    apply_b(got, id, resp);
    total++;
    if ({got, resp} !== 3'b110) begin
      bad++; $display("[TB] FAIL beat_limit_bresp got=%b/%b required=1/10", got, resp);
    end
    DBG_ADDR = 32'hE4; #1;
    total++;
    if (DBG_RDATA !== 32'h2) begin
      bad++; $display("[TB] FAIL beat_limit_mem got=%h required=2", DBG_RDATA);
    end
  endtask

  task automatic test_out_of_range;
    logic got; logic [3:0] id; logic [1:0] resp;
    apply_aw(4'h4, 32'h1000, 8'd0, 2'b01);
    apply_w(32'hDEAD_BEEF, 4'hF, 1'b1);
    apply_b(got, id, resp);
    total++;
    if ({got, id, resp} !== {1'b1, 4'h4, 2'b10}) begin
      bad++; $display("[TB] FAIL oor_bresp got=%b/%h/%b required=1/4/10", got, id, resp);
    end
    DBG_ADDR = 32'h0; #1;
    total++;
    if (DBG_RDATA[15:0] !== 16'hBBAA) begin
      bad++; $display("[TB] FAIL oor_no_alias got=%h required=BBAA", DBG_RDATA[15:0]);
    end
    DBG_ADDR = 32'h1000; #1;
    total++;
    if (DBG_RDATA !== 32'h0) begin
      bad++; $display("[TB] FAIL oor_dbg_zero got=%h required=0", DBG_RDATA);
    end
  endtask

  task automatic test_bad_burst;
    logic got; logic [3:0] id; logic [1:0] resp;
    apply_aw(4'h8, 32'hC0, 8'd2, 2'b10);
    for (int i = 0; i < 3; i++) apply_w(32'h31 + 32'(i), 4'hF, i == 2);
    apply_b(got, id, resp);
    total++;
    if ({got, resp} !== 3'b110) begin
      bad++; $display("[TB] FAIL badwrap_bresp got=%b/%b required=1/10", got, resp);
    end
    DBG_ADDR = 32'hC8; #1;
    total++;
    if (DBG_RDATA !== 32'h33) begin
      bad++; $display("[TB] FAIL badwrap_as_incr got=%h required=33", DBG_RDATA);
    end
    apply_aw(4'h9, 32'hD0, 8'd1, 2'b11);
    apply_w(32'h41, 4'hF, 1'b0);
    apply_w(32'h42, 4'hF, 1'b1);
    apply_b(got, id, resp);
    total++;
    if ({got, resp} !== 3'b110) begin
      bad++; $display("[TB] FAIL rsvd_bresp got=%b/%b required=1/10", got, resp);
    end
    DBG_ADDR = 32'hD4; #1;
    total++;
    if (DBG_RDATA !== 32'h42) begin
      bad++; $display("[TB] FAIL rsvd_as_incr got=%h required=42", DBG_RDATA);
    end
  endtask

  task automatic test_bready_stall;
    logic got; logic [3:0] id; logic [1:0] resp;
    apply_aw(4'h9, 32'h40, 8'd0, 2'b01);
    apply_w(32'h55, 4'hF, 1'b1);
    BREADY = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge ACLK); #1;
      total++;
      if ({BVALID, BID, BRESP, AWREADY} !== {1'b1, 4'h9, 2'b00, 1'b0}) begin
        bad++; $display("[TB] FAIL stall_hold[%0d] got=%b/%h/%b/%b required=1/9/00/0",
                        c, BVALID, BID, BRESP, AWREADY);
      end
    end
    apply_b(got, id, resp);
    total++;
    if ({got, id, resp, AWREADY, BVALID} !== {1'b1, 4'h9, 2'b00, 1'b1, 1'b0}) begin
      bad++; $display("[TB] FAIL stall_release got=%b/%h/%b/%b/%b required=1/9/00/1/0",
                      got, id, resp, AWREADY, BVALID);
    end
  endtask

  task automatic test_reset_mid_burst;
    apply_aw(4'h2, 32'h60, 8'd3, 2'b01);
    apply_w(32'h111, 4'hF, 1'b0);
    apply_w(32'h222, 4'hF, 1'b0);
    ARESETn = 1'b0; #1;
    total++;
    if ({AWREADY, WREADY, BVALID} !== 3'b000) begin
      bad++; $display("[TB] FAIL midreset_async got=%b required=000", {AWREADY, WREADY, BVALID});
    end
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    total++;
    if ({AWREADY, BVALID} !== 2'b10) begin
      bad++; $display("[TB] FAIL midreset_release got=%b required=10", {AWREADY, BVALID});
    end
    DBG_ADDR = 32'h64; #1;
    total++;
    if (DBG_RDATA !== 32'h222) begin
      bad++; $display("[TB] FAIL midreset_persist got=%h required=222", DBG_RDATA);
    end
  endtask

  task automatic test_back_to_back;
    logic got; logic [3:0] id; logic [1:0] resp;
    for (int k = 0; k < 2; k++) begin
      apply_aw(4'(k + 10), 32'h100 + 32'(8 * k), 8'd1, 2'b01);
      apply_w(32'h500 + 32'(k), 4'hF, 1'b0);
      apply_w(32'h600 + 32'(k), 4'hF, 1'b1);
      apply_b(got, id, resp);
      total++;
      if ({got, id, resp} !== {1'b1, 4'(k + 10), 2'b00}) begin
        bad++; $display("[TB] FAIL b2b_bresp[%0d] got=%b/%h/%b required=1/%h/00", k, got, id, resp, k + 10);
      end
    end
    DBG_ADDR = 32'h10C; #1;
    total++;
    if (DBG_RDATA !== 32'h601) begin
      bad++; $display("[TB] FAIL b2b_mem got=%h required=601", DBG_RDATA);
    end
  endtask

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    total = 0; bad = 0;
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b0; DBG_ADDR = '0;

    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_early_wlast();
    test_beat_limit();
    test_out_of_range();
    test_bad_burst();
    test_bready_stall();
    test_reset_mid_burst();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_write_slave.md
AXI_WRITE_SLAVE -- requirements
Module: axi_write_slave

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width; STRB = DATA_WIDTH/8.
REQ-004 SHALL have parameter MEM_DEPTH, default 1024, memory depth in words.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: ACLK  in  1  clock; ARESETn  in  1  async active-low reset.
REQ-006 AWID  in  ID_WIDTH  write ID.
REQ-007 AWADDR  in  ADDR_WIDTH  burst start byte address.
REQ-008 AWLEN  in  8  beats minus one.
REQ-009 AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP.
REQ-010 AWVALID  in  1 / AWREADY  out  1  address handshake.
REQ-011 WDATA  in  DATA_WIDTH  write data.
REQ-012 WSTRB  in  STRB  byte enables.
REQ-013 WLAST  in  1  last beat marker.
REQ-014 WVALID  in  1 / WREADY  out  1  data handshake.
REQ-015 BID  out  ID_WIDTH  response ID; BRESP  out  2  response.
REQ-016 BVALID  out  1 / BREADY  in  1  response handshake.
REQ-017 DBG_ADDR  in  ADDR_WIDTH / DBG_RDATA  out  DATA_WIDTH  combinational backdoor read.

Function
REQ-018 SHALL implement FSM IDLE -> DATA -> RESP -> IDLE, one burst outstanding.
- AWREADY, WREADY, BVALID registered; high only in IDLE, DATA, RESP respectively.
REQ-019 AW handshake at cycle N SHALL latch AWID, AWADDR, AWLEN and AWBURST, clear the beat counter, and assert WREADY at N+1.
REQ-020 Each W handshake SHALL write the enabled bytes to word AWADDR>>log2(STRB), then advance the address.
- FIXED: address unchanged.
- INCR: address += STRB.
- WRAP: address wraps within an (AWLEN+1)*STRB-byte aligned window.
REQ-021 Burst SHALL end on the earlier of a WLAST beat or beat AWLEN+1. The last W handshake at cycle M SHALL give BVALID=1 at M+1.
REQ-022 BVALID, BID and BRESP SHALL hold stable until BREADY; a B handshake at K SHALL give AWREADY=1 at K+1.
REQ-023 BRESP SHALL be OKAY(00) unless any of the following occurred, in which case it SHALL be SLVERR(10):
- WLAST disagrees with beat count;
- a beat addressed a word >= MEM_DEPTH (write suppressed);
- AWBURST=11 (treated as INCR);
- WRAP with AWLEN not in {1,3,7,15} (treated as INCR).
REQ-024 DBG_RDATA SHALL return the memory word at DBG_ADDR>>log2(STRB), or 0 if out of range.
REQ-025 WVALID while not in DATA SHALL be ignored; AWVALID outside IDLE SHALL wait.

Reset
REQ-026 ARESETn low SHALL asynchronously force IDLE, AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=00, and counters to 0.
REQ-027 Memory SHALL NOT be reset.
REQ-028 AWREADY SHALL rise on the first ACLK edge after reset release.
REQ-029 Reset mid-burst SHALL abort with no B response; beats already written SHALL persist.

Configuration
REQ-030 Macro AXI_WRITE_SLAVE_WAIT_EN, when defined, SHALL gate WREADY in DATA with bit 0 of an 8-bit LFSR.
- Polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, advancing every cycle.
REQ-031 Without AXI_WRITE_SLAVE_WAIT_EN, WREADY SHALL be 1 throughout DATA.

Verification
REQ-032 INCR burst, AWADDR=0x10, AWLEN=3, data 1..4, WLAST on beat 4 -> words 4..7 = 1..4, BRESP=00, BID=AWID.
REQ-033 WRAP burst, AWADDR=0x38, AWLEN=3 -> beats written to 0x38, 0x3C, 0x30, 0x34; BRESP=00.
REQ-034 FIXED burst, AWADDR=0x0, AWLEN=1, WSTRB=0001 then 0010, data 0xAA/0xBB00 -> word0 low bytes = 0xBBAA.
REQ-035 AWLEN=3 with WLAST on beat 2 -> burst ends after beat 2, BRESP=10; AWADDR=MEM_DEPTH*4 -> no write, BRESP=10.
REQ-036 BREADY held low 5 cycles -> BVALID/BID/BRESP stable, AWREADY low. ARESETn pulsed mid-burst -> no BVALID, AWREADY high one edge after release.
